// File: rtl/tv80_bus_bridge.sv
// rtl/tv80_bus_bridge.sv - TV80 Z80-style bus strobes to a req/ack downstream bus
//
// Purpose:
//   Turns one Z80 memory or I/O cycle into at most one downstream request.
//   The CPU is held with wait_n while the request is outstanding. An
//   unanswered request is aborted after TIMEOUT cycles. Interrupt-acknowledge
//   cycles are answered locally with INTACK_VEC.
//
// Parameters:
//   TIMEOUT     max cycles spent in REQ before abort (1..255)
//   INTACK_VEC  data returned to the CPU on interrupt-acknowledge cycles
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mreq_n, iorq_n, rd_n, wr_n, m1_n CPU strobes, active-low
//   A, cpu_do                        CPU address and write data
//   cpu_di                           registered read data to the CPU
//   wait_n                           wait request to the CPU, active-low
//   bus_req, bus_we, bus_io          downstream request, write and I/O flags
//   bus_addr, bus_wdata              latched request address and write data
//   bus_ack, bus_rdata               downstream completion and read data
//   bus_err                          one-cycle pulse on timeout abort

module tv80_bus_bridge #(
  parameter int          TIMEOUT    = 255,
  parameter logic [7:0]  INTACK_VEC = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic        bus_err
);

  // Code 2'b11 is unused and falls back to IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Last counter value before abort: REQ lasts exactly TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cpu_di_q, cpu_di_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_io_q, bus_io_d;
  logic        bus_err_q, bus_err_d;

  logic cyc_start;
  logic intack;

  // Refresh drives mreq_n without rd_n/wr_n, so it never qualifies.
  assign cyc_start = (state_q == S_IDLE) && (!mreq_n || !iorq_n) && (!rd_n || !wr_n);
  assign intack    = cyc_start && !iorq_n && !m1_n;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      cpu_di_q    <= 8'd0;
      bus_addr_q  <= 16'd0;
      bus_wdata_q <= 8'd0;
      bus_we_q    <= 1'b0;
      bus_io_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_di_q    <= cpu_di_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      bus_io_q    <= bus_io_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_di_d    = cpu_di_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = bus_we_q;
    bus_io_d    = bus_io_q;
    bus_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (intack) begin
          cpu_di_d = INTACK_VEC;
          state_d  = S_DONE;
        end else if (cyc_start) begin
          // Request fields are frozen here and held for the whole REQ phase.
          bus_addr_d  = A;
          bus_we_d    = !wr_n;
          bus_io_d    = !iorq_n;
          bus_wdata_d = cpu_do;
          cnt_d       = 8'd0;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        // Strobes are not looked at here: only ack or timeout ends REQ.
        // Ack is tested first so it wins over a coincident timeout.
        if (bus_ack) begin
          if (!bus_we_q) begin
            cpu_di_d = bus_rdata;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          cpu_di_d  = 8'hFF;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        // Wait for the CPU to end its cycle so one Z80 cycle is one request.
        if (mreq_n && iorq_n) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus_req   = (state_q == S_REQ);
    // Reset forces wait_n high even before the first clock edge settles state.
    wait_n    = reset || !((state_q == S_REQ) || (cyc_start && !intack));
    cpu_di    = cpu_di_q;
    bus_addr  = bus_addr_q;
    bus_wdata = bus_wdata_q;
    bus_we    = bus_we_q;
    bus_io    = bus_io_q;
    bus_err   = bus_err_q;
  end

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// tb/tb_tv80_bus_bridge.sv - directed self-checking bench for tv80_bus_bridge

module tb_tv80_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic [15:0] A;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        wait_n;
  logic        bus_req, bus_we, bus_io;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  int          reqn, waitlow, errn, unstable;
  logic [15:0] seen_addr;
  logic [7:0]  seen_wdata;
  logic        seen_we, seen_io;

  tv80_bus_bridge #(.TIMEOUT(4), .INTACK_VEC(8'hC7)) dut (
    .clk(clk), .reset(reset),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .A(A), .cpu_do(cpu_do), .cpu_di(cpu_di), .wait_n(wait_n),
    .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic strobes(input logic mq, input logic iq, input logic rd, input logic wr, input logic m1);
    mreq_n = mq; iorq_n = iq; rd_n = rd; wr_n = wr; m1_n = m1;
  endtask

  task automatic clear_counts();
    reqn = 0; waitlow = 0; errn = 0; unstable = 0;
    seen_addr = 16'h0; seen_wdata = 8'h0; seen_we = 1'b0; seen_io = 1'b0;
  endtask

  // Runs n cycles from a negedge, counting bus_req / wait_n-low / bus_err
  // cycles and acking during the ack_at-th request cycle (0 = never).
  task automatic run(input int n, input int ack_at, input logic [7:0] rdata);
    for (int k = 0; k < n; k++) begin
      #1;
      if (bus_req) begin
        reqn++;
        if (reqn == 1) begin
          seen_addr = bus_addr; seen_wdata = bus_wdata; seen_we = bus_we; seen_io = bus_io;
        end else if (bus_addr !== seen_addr || bus_wdata !== seen_wdata ||
                     bus_we !== seen_we || bus_io !== seen_io) begin
          unstable++;
        end
      end
      if (wait_n === 1'b0) waitlow++;
      if (bus_err === 1'b1) errn++;
      bus_rdata = rdata;
      bus_ack   = bus_req && (reqn == ack_at);
      @(negedge clk);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    strobes(1, 1, 1, 1, 1);
    A = 16'h0; cpu_do = 8'h0; bus_ack = 1'b0; bus_rdata = 8'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_io !== 1'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: req=%b we=%b io=%b err=%b required 0000", bus_req, bus_we, bus_io, bus_err);
    end
    checks++;
    if (bus_addr !== 16'h0 || bus_wdata !== 8'h0 || cpu_di !== 8'h0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h cpu_di=%h required 0000 00 00", bus_addr, bus_wdata, cpu_di);
    end
    checks++;
    if (wait_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_wait_n: got %b required 1", wait_n);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mem_read();
    clear_counts();
    A = 16'h1234;
    strobes(0, 1, 0, 1, 1);
    run(6, 3, 8'hA5);
    strobes(1, 1, 1, 1, 1);
    run(2, 0, 8'h00);
    checks++;
    if (reqn != 3) begin failures++; $display("FAIL rd_req_cycles: got %0d required 3", reqn); end
    checks++;
    if (waitlow != 4) begin failures++; $display("FAIL rd_wait_cycles: got %0d required 4", waitlow); end
    checks++;
    if (seen_addr !== 16'h1234 || seen_we !== 1'b0 || seen_io !== 1'b0) begin
      failures++;
      $display("FAIL rd_fields: addr=%h we=%b io=%b required 1234 0 0", seen_addr, seen_we, seen_io);
    end
    checks++;
    if (unstable != 0) begin failures++; $display("FAIL rd_stable: %0d changed cycles required 0", unstable); end
    checks++;
    if (cpu_di !== 8'hA5) begin failures++; $display("FAIL rd_cpu_di: got %h required a5", cpu_di); end
    checks++;
    if (errn != 0) begin failures++; $display("FAIL rd_no_err: got %0d required 0", errn); end
    #1;
    checks++;
    if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
      failures++;
      $display("FAIL rd_idle: req=%b wait_n=%b required 0 1", bus_req, wait_n);
    end
  endtask

  task automatic test_io_write();
    clear_counts();
    A = 16'h00FE; cpu_do = 8'h3C;
    strobes(1, 0, 1, 0, 1);
    run(4, 1, 8'h99);
    strobes(1, 1, 1, 1, 1);
    run(2, 0, 8'h00);
    checks++;
    if (reqn != 1) begin failures++; $display("FAIL wr_req_cycles: got %0d required 1", reqn); end
    checks++;
    if (waitlow != 2) begin failures++; $display("FAIL wr_wait_cycles: got %0d required 2", waitlow); end
    checks++;
    if (seen_addr !== 16'h00FE || seen_we !== 1'b1 || seen_io !== 1'b1 || seen_wdata !== 8'h3C) begin
      failures++;
      $display("FAIL wr_fields: addr=%h we=%b io=%b wdata=%h required 00fe 1 1 3c",
               seen_addr, seen_we, seen_io, seen_wdata);
    end
    checks++;
    if (cpu_di !== 8'hA5) begin failures++; $display("FAIL wr_cpu_di_kept: got %h required a5", cpu_di); end
  endtask

  task automatic test_intack();
    clear_counts();
    A = 16'h0038;
    strobes(1, 0, 0, 1, 0);
    run(4, 1, 8'h11);
    strobes(1, 1, 1, 1, 1);
    run(2, 0, 8'h00);
    checks++;
    if (reqn != 0) begin failures++; $display("FAIL intack_no_req: got %0d required 0", reqn); end
    checks++;
    if (waitlow != 0) begin failures++; $display("FAIL intack_no_wait: got %0d required 0", waitlow); end
    checks++;
    if (cpu_di !== 8'hC7) begin failures++; $display("FAIL intack_cpu_di: got %h required c7", cpu_di); end
  endtask

  task automatic test_timeout();
    clear_counts();
    A = 16'h4000;
    strobes(0, 1, 0, 1, 1);
    run(8, 0, 8'h55);
    strobes(1, 1, 1, 1, 1);
    run(2, 0, 8'h00);
    checks++;
    if (reqn != 4) begin failures++; $display("FAIL to_req_cycles: got %0d required 4", reqn); end
    checks++;
    if (errn != 1) begin failures++; $display("FAIL to_err_pulses: got %0d required 1", errn); end
    checks++;
    if (waitlow != 5) begin failures++; $display("FAIL to_wait_cycles: got %0d required 5", waitlow); end
    checks++;
    if (cpu_di !== 8'hFF) begin failures++; $display("FAIL to_cpu_di: got %h required ff", cpu_di); end
    #1;
    checks++;
    if (bus_req !== 1'b0 || wait_n !== 1'b1 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL to_idle: req=%b wait_n=%b err=%b required 0 1 0", bus_req, wait_n, bus_err);
    end
  endtask

  task automatic test_refresh();
    clear_counts();
    A = 16'h0077;
    strobes(0, 1, 1, 1, 0);
    run(4, 1, 8'h00);
    strobes(1, 1, 1, 1, 1);
    run(1, 0, 8'h00);
    checks++;
    if (reqn != 0 || waitlow != 0) begin
      failures++;
      $display("FAIL refresh_ignored: req=%0d waitlow=%0d required 0 0", reqn, waitlow);
    end
  endtask

  task automatic test_ack_at_timeout();
    clear_counts();
    A = 16'h8001;
    strobes(0, 1, 0, 1, 1);
    run(8, 4, 8'h5A);
    strobes(1, 1, 1, 1, 1);
    run(2, 0, 8'h00);
    checks++;
    if (reqn != 4) begin failures++; $display("FAIL ackto_req_cycles: got %0d required 4", reqn); end
    checks++;
    if (errn != 0) begin failures++; $display("FAIL ackto_no_err: got %0d required 0", errn); end
    checks++;
    if (cpu_di !== 8'h5A) begin failures++; $display("FAIL ackto_cpu_di: got %h required 5a", cpu_di); end
  endtask

  task automatic test_strobe_release();
    clear_counts();
    A = 16'h2222;
    strobes(0, 1, 0, 1, 1);
    run(2, 0, 8'h00);
    strobes(1, 1, 1, 1, 1);
    run(4, 3, 8'h3D);
    checks++;
    if (reqn != 3) begin failures++; $display("FAIL rel_req_cycles: got %0d required 3", reqn); end
    checks++;
    if (cpu_di !== 8'h3D) begin failures++; $display("FAIL rel_cpu_di: got %h required 3d", cpu_di); end
    #1;
    checks++;
    if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
      failures++;
      $display("FAIL rel_idle: req=%b wait_n=%b required 0 1", bus_req, wait_n);
    end
  endtask

  task automatic test_reset_mid_req();
    clear_counts();
    A = 16'h3333;
    strobes(0, 1, 0, 1, 1);
    run(2, 0, 8'h00);
    #1;
    checks++;
    if (bus_req !== 1'b1) begin failures++; $display("FAIL rst_in_req: req=%b required 1", bus_req); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_drop: req=%b wait_n=%b required 0 1", bus_req, wait_n);
    end
    reset = 1'b0;
    strobes(1, 1, 1, 1, 1);
    bus_rdata = 8'h77;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b0 || bus_err !== 1'b0 || cpu_di !== 8'h00 || wait_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_late_ack: req=%b err=%b cpu_di=%h wait_n=%b required 0 0 00 1",
               bus_req, bus_err, cpu_di, wait_n);
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_intack();
    test_timeout();
    test_refresh();
    test_ack_at_timeout();
    test_strobe_release();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
